// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO between IF and ID, carrying {pc, without_prediction, inst}.
// Valid/ready handshakes on both sides. flush empties the queue in one cycle.
// When the queue is empty the outputs show an all-zero bubble.
// Optional feature: define IF_ID_QUEUE_BYPASS_EN so an empty queue forwards
// the IF entry straight to ID in the same cycle (0-cycle latency).
module if_id_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          without_prediction_i,
   input  logic [XLEN-1:0]          inst_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          pc_o,
   output logic [XLEN-1:0]          without_prediction_o,
   output logic [XLEN-1:0]          inst_o,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [3*XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;

   logic              empty;
   logic              bypass;
   logic              push;
   logic              pop;
   logic              store;
   logic              take;
   logic [3*XLEN-1:0] head;

   assign count = count_q;

   // Handshake decode and head-entry presentation; in_ready looks only at registered occupancy
   always_comb begin
      empty    = (count_q == '0);
      in_ready = (count_q != FULL_COUNT);
      push     = in_valid & in_ready;
`ifdef IF_ID_QUEUE_BYPASS_EN
      bypass   = empty & in_valid & ~flush;
      head     = bypass ? {pc_i, without_prediction_i, inst_i} : mem[rd_ptr];
`else
      bypass   = 1'b0;
      head     = mem[rd_ptr];
`endif
      out_valid = ~empty | bypass;
      pop       = out_valid & out_ready;
      store     = push & ~(bypass & out_ready);
      take      = pop & ~bypass;
      {pc_o, without_prediction_o, inst_o} = out_valid ? head : '0;
   end

   // Pointer and occupancy update; flush wins over any same-cycle push or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (store) wr_ptr <= wr_ptr + AW'(1);
         if (take)  rd_ptr <= rd_ptr + AW'(1);
         case ({store, take})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; not reset since occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (store && !flush) mem[wr_ptr] <= {pc_i, without_prediction_i, inst_i};
   end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and randomized traffic through if_id_queue, checked by a
// queue-based reference model. Follows IF_ID_QUEUE_BYPASS_EN the same way the design does.
module tb_if_id_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] wp;
      logic [XLEN-1:0] inst;
   } entry_t;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] without_prediction_i;
   logic [XLEN-1:0] inst_i;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] without_prediction_o;
   logic [XLEN-1:0] inst_o;
   logic [CW-1:0]   count;

   entry_t exp_q[$];
   int     vectors     = 0;
   int     miscompares = 0;

   if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .flush                (flush),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .pc_i                 (pc_i),
      .without_prediction_i (without_prediction_i),
      .inst_i               (inst_i),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .pc_o                 (pc_o),
      .without_prediction_o (without_prediction_o),
      .inst_o               (inst_o),
      .count                (count)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge
   task automatic applyStimulus(input logic iv, input logic ordy, input logic fl,
                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
      @(posedge clk);
      #1;
      in_valid             = iv;
      out_ready            = ordy;
      flush                = fl;
      pc_i                 = pc;
      without_prediction_i = pc + 32'd4;
      inst_i               = inst;
   endtask

   // Assert reset in the middle of a cycle and check that it takes effect without a clock edge
   task automatic doAsyncReset();
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      #1;
      checkOutput("rst_count",     32'(count),     32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
      checkOutput("rst_pc_o",      pc_o,           32'd0);
      checkOutput("rst_wp_o",      without_prediction_o, 32'd0);
      checkOutput("rst_inst_o",    inst_o,         32'd0);
      exp_q.delete();
      #4;
      rst_n = 1'b1;
   endtask

   // Monitor: compare DUT against the reference queue mid-cycle, then advance the model
   always @(negedge clk) begin : monitor
      entry_t e;
      entry_t fresh;
      bit     bp;
      bit     exp_valid;
      bit     exp_ready;
      if (rst_n) begin
         fresh.pc   = pc_i;
         fresh.wp   = without_prediction_i;
         fresh.inst = inst_i;
         bp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
         bp = (exp_q.size() == 0) && in_valid && !flush;
`endif
         exp_valid = (exp_q.size() != 0) || bp;
         exp_ready = (exp_q.size() != DEPTH);
         checkOutput("count",     32'(count),     32'(exp_q.size()));
         checkOutput("in_ready",  32'(in_ready),  32'(exp_ready));
         checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
         if (bp) e = fresh;
         else if (exp_valid) e = exp_q[0];
         else begin
            e.pc = '0; e.wp = '0; e.inst = '0;
         end
         checkOutput("pc_o",   pc_o,                 e.pc);
         checkOutput("wp_o",   without_prediction_o, e.wp);
         checkOutput("inst_o", inst_o,               e.inst);
         if (flush) begin
            exp_q.delete();
         end else if (bp) begin
            if (!out_ready) exp_q.push_back(fresh);
         end else begin
            if (exp_valid && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_ready) exp_q.push_back(fresh);
         end
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      pc_i = '0; without_prediction_i = '0; inst_i = '0;
      #12;
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // fill to full, then a held fifth entry
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4*k), 32'h1000 + 32'(k));
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h110, 32'h1004);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h110, 32'h1004);
      // full + pop: no push this cycle, accepted the next, then drain
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h110, 32'h1004);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h110, 32'h1004);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      // flush with simultaneous push and pop
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h180 + 32'(4*k), 32'h2000 + 32'(k));
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hDEAD);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      // asynchronous reset with three entries held
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h1C0 + 32'(4*k), 32'h3000 + 32'(k));
      doAsyncReset();

      // concurrent push and pop at steady occupancy of two
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h1F0, 32'h4000);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h1F4, 32'h4001);
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h200 + 32'(4*k), 32'h5000 + 32'(k));
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      // empty queue, entry offered with ID ready
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h00000013);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      // randomized traffic with occasional flush and one mid-run reset
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) doAsyncReset();
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 15) == 0), $urandom, $urandom);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
